// File: rtl/display_arbiter.sv
// Display arbiter: three sources compete for one 5-digit 7-segment display.
// A new owner keeps the display for a minimum tenure (HOLD). After that, in
// OPEN, a higher-priority source may take over, or the owner keeps the display
// while it still requests. Digits are shown with optional per-source blinking.
module display_arbiter #(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int BLINK_HALF  = 12_500_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [2:0]  blink_en,
   input  logic [19:0] src0_digits,
   input  logic [19:0] src1_digits,
   input  logic [19:0] src2_digits,
   output logic [3:0]  digit_0,
   output logic [3:0]  digit_1,
   output logic [3:0]  digit_2,
   output logic [3:0]  digit_3,
   output logic [3:0]  digit_4,
   output logic [2:0]  grant,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      OPEN = 2'd2
   } state_t;

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
   localparam logic [19:0]   ALL_BLANK  = 20'hFFFFF;

   // Bit 0 wins, bit 2 loses; result is one-hot or zero.
   function automatic logic [2:0] pick_highest(input logic [2:0] r);
      logic [2:0] p;
      if (r[0]) begin
         p = 3'b001;
      end else if (r[1]) begin
         p = 3'b010;
      end else if (r[2]) begin
         p = 3'b100;
      end else begin
         p = 3'b000;
      end
      return p;
   endfunction

   state_t        state_q, state_d;
   logic [2:0]    grant_q, grant_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic [19:0]   digits_q, digits_d;
   logic          busy_q, busy_d;
   logic [2:0]    hi_req_s;
   logic [19:0]   owner_digits_s;
   logic          owner_blink_s;

   // Requests strictly above the current owner in priority (owner is one-hot).
   assign hi_req_s = req & (grant_q - 3'd1);

   // Arbitration FSM next state: owner selection and tenure countdown.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         IDLE: begin
            if (req != 3'b000) begin
               grant_d    = pick_highest(req);
               hold_cnt_d = HOLD_LOAD;
               state_d    = HOLD;
            end else begin
               grant_d    = 3'b000;
               hold_cnt_d = '0;
               state_d    = IDLE;
            end
         end
         HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d = OPEN;
            end else begin
               hold_cnt_d = hold_cnt_q - HW'(1);
            end
         end
         OPEN: begin
            if (hi_req_s != 3'b000) begin
               grant_d    = pick_highest(hi_req_s);
               hold_cnt_d = HOLD_LOAD;
               state_d    = HOLD;
            end else if ((req & grant_q) != 3'b000) begin
               state_d = OPEN;
            end else if (req != 3'b000) begin
               grant_d    = pick_highest(req);
               hold_cnt_d = HOLD_LOAD;
               state_d    = HOLD;
            end else begin
               grant_d    = 3'b000;
               hold_cnt_d = '0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d    = IDLE;
            grant_d    = 3'b000;
            hold_cnt_d = '0;
         end
      endcase
   end

   // Blink timer: restarts in the visible half whenever ownership changes.
   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if ((grant_d != grant_q) || (grant_d == 3'b000)) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
      end
   end

   // Digit source: the owner taking effect at this edge, blanked in the blink-off half.
   always_comb begin
      owner_digits_s = ALL_BLANK;
      case (grant_d)
         3'b001:  owner_digits_s = src0_digits;
         3'b010:  owner_digits_s = src1_digits;
         3'b100:  owner_digits_s = src2_digits;
         default: owner_digits_s = ALL_BLANK;
      endcase
      owner_blink_s = |(blink_en & grant_d);
      if ((grant_d == 3'b000) || (owner_blink_s && blink_phase_d)) begin
         digits_d = ALL_BLANK;
      end else begin
         digits_d = owner_digits_s;
      end
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= 3'b000;
         hold_cnt_q    <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         digits_q      <= ALL_BLANK;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         hold_cnt_q    <= hold_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         digits_q      <= digits_d;
         busy_q        <= busy_d;
      end
   end

   assign grant   = grant_q;
   assign busy    = busy_q;
   assign digit_0 = digits_q[3:0];
   assign digit_1 = digits_q[7:4];
   assign digit_2 = digits_q[11:8];
   assign digit_3 = digits_q[15:12];
   assign digit_4 = digits_q[19:16];

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYCLES = 4, BLINK_HALF = 3.
module tb_display_arbiter;

   logic        clk;
   logic        reset;
   logic [2:0]  req;
   logic [2:0]  blink_en;
   logic [19:0] src0_digits, src1_digits, src2_digits;
   logic [3:0]  digit_0, digit_1, digit_2, digit_3, digit_4;
   logic [2:0]  grant;
   logic        busy;
   logic [19:0] digits_s;

   int vectors;
   int miscompares;

   display_arbiter #(.HOLD_CYCLES(4), .BLINK_HALF(3)) dut (
      .clk(clk), .reset(reset), .req(req), .blink_en(blink_en),
      .src0_digits(src0_digits), .src1_digits(src1_digits), .src2_digits(src2_digits),
      .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2),
      .digit_3(digit_3), .digit_4(digit_4), .grant(grant), .busy(busy)
   );

   assign digits_s = {digit_4, digit_3, digit_2, digit_1, digit_0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 3'b000;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (grant !== 3'b000 || busy !== 1'b0 || digits_s !== 20'hFFFFF) begin
         miscompares++;
         $display("FAIL reset: grant=%b busy=%b digits=%h, want 000 0 fffff", grant, busy, digits_s);
      end
      step();
      vectors++;
      if (grant !== 3'b000 || busy !== 1'b0 || digits_s !== 20'hFFFFF) begin
         miscompares++;
         $display("FAIL idle_noreq: grant=%b busy=%b digits=%h, want 000 0 fffff", grant, busy, digits_s);
      end
   endtask

   task automatic test_basic_grant();
      do_reset();
      src2_digits = 20'h12345;
      req = 3'b100;
      step();
      vectors++;
      if (grant !== 3'b100 || busy !== 1'b1 || digits_s !== 20'h12345) begin
         miscompares++;
         $display("FAIL basic_grant: grant=%b busy=%b digits=%h, want 100 1 12345", grant, busy, digits_s);
      end
   endtask

   task automatic test_no_preempt();
      do_reset();
      req = 3'b100;
      step();
      req = 3'b101;
      for (int i = 2; i <= 5; i++) begin
         step();
         vectors++;
         if (grant !== 3'b100) begin
            miscompares++;
            $display("FAIL no_preempt cyc%0d: grant=%b, want 100", i, grant);
         end
      end
      step();
      vectors++;
      if (grant !== 3'b001 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL preempt_in_open: grant=%b busy=%b, want 001 1", grant, busy);
      end
   endtask

   task automatic test_owner_drop();
      do_reset();
      src1_digits = 20'h67890;
      req = 3'b010;
      step();
      req = 3'b000;
      for (int i = 2; i <= 5; i++) begin
         step();
         vectors++;
         if (grant !== 3'b010 || busy !== 1'b1 || digits_s !== 20'h67890) begin
            miscompares++;
            $display("FAIL owner_drop cyc%0d: grant=%b busy=%b digits=%h, want 010 1 67890", i, grant, busy, digits_s);
         end
      end
      step();
      vectors++;
      if (grant !== 3'b000 || busy !== 1'b0 || digits_s !== 20'hFFFFF) begin
         miscompares++;
         $display("FAIL owner_drop_idle: grant=%b busy=%b digits=%h, want 000 0 fffff", grant, busy, digits_s);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      req = 3'b110;
      step();
      vectors++;
      if (grant !== 3'b010) begin
         miscompares++;
         $display("FAIL simultaneous: grant=%b, want 010", grant);
      end
   endtask

   task automatic test_blink();
      logic [19:0] exp;
      do_reset();
      src1_digits = 20'h00042;
      blink_en = 3'b010;
      req = 3'b010;
      for (int i = 0; i < 9; i++) begin
         step();
         exp = ((i % 6) < 3) ? 20'h00042 : 20'hFFFFF;
         vectors++;
         if (digits_s !== exp || grant !== 3'b010) begin
            miscompares++;
            $display("FAIL blink cyc%0d: digits=%h grant=%b, want %h 010", i, digits_s, grant, exp);
         end
      end
      // Cycle 9 would be blank; disabling blink shows digits immediately.
      blink_en = 3'b000;
      step();
      vectors++;
      if (digits_s !== 20'h00042) begin
         miscompares++;
         $display("FAIL blink_off: digits=%h, want 00042", digits_s);
      end
      blink_en = 3'b010;
      step();
      vectors++;
      if (digits_s !== 20'hFFFFF) begin
         miscompares++;
         $display("FAIL blink_reenable: digits=%h, want fffff", digits_s);
      end
      blink_en = 3'b000;
   endtask

   task automatic test_live_passthrough();
      do_reset();
      src0_digits = 20'hABCDE;
      req = 3'b001;
      step();
      vectors++;
      if (digits_s !== 20'hABCDE) begin
         miscompares++;
         $display("FAIL passthrough_hex: digits=%h, want abcde", digits_s);
      end
      src0_digits = 20'h9F071;
      step();
      vectors++;
      if (digits_s !== 20'h9F071) begin
         miscompares++;
         $display("FAIL live_update: digits=%h, want 9f071", digits_s);
      end
   endtask

   task automatic test_open_lower();
      do_reset();
      req = 3'b001;
      for (int i = 1; i <= 5; i++) step();
      vectors++;
      if (grant !== 3'b001 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL open_hold_owner: grant=%b busy=%b, want 001 1", grant, busy);
      end
      step();
      vectors++;
      if (grant !== 3'b001) begin
         miscompares++;
         $display("FAIL open_stay: grant=%b, want 001", grant);
      end
      req = 3'b100;
      step();
      vectors++;
      if (grant !== 3'b100 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL open_lower_pending: grant=%b busy=%b, want 100 1", grant, busy);
      end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      req = 3'b010;
      step();
      step();
      reset = 1'b1;
      step();
      vectors++;
      if (grant !== 3'b000 || busy !== 1'b0 || digits_s !== 20'hFFFFF) begin
         miscompares++;
         $display("FAIL reset_mid_hold: grant=%b busy=%b digits=%h, want 000 0 fffff", grant, busy, digits_s);
      end
      reset = 1'b0;
      req = 3'b001;
      step();
      req = 3'b000;
      for (int i = 2; i <= 5; i++) begin
         step();
         vectors++;
         if (grant !== 3'b001 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL fresh_hold cyc%0d: grant=%b busy=%b, want 001 1", i, grant, busy);
         end
      end
      step();
      vectors++;
      if (grant !== 3'b000 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL fresh_hold_end: grant=%b busy=%b, want 000 0", grant, busy);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      req         = 3'b000;
      blink_en    = 3'b000;
      src0_digits = 20'h00000;
      src1_digits = 20'h00000;
      src2_digits = 20'h00000;
      test_reset();
      test_basic_grant();
      test_no_preempt();
      test_owner_drop();
      test_simultaneous();
      test_blink();
      test_live_passthrough();
      test_open_lower();
      test_reset_mid_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000, minimum grant tenure in clk cycles (legal range >= 1).
REQ-002 Parameter BLINK_HALF, default 12_500_000, blink half-period in clk cycles (legal range >= 1).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  display requests; bit 0 is the highest priority, bit 2 the lowest.
REQ-006 blink_en  input  3  per-source blink enable; sampled only for the current owner.
REQ-007 src0_digits, src1_digits, src2_digits  input  20 each  packed {d4,d3,d2,d1,d0} BCD nibbles, d0 = rightmost digit.
REQ-008 digit_0..digit_4  output  4 each  registered nibbles driving the 5-digit 7-segment multiplexer; 4'hF = blank.
REQ-009 grant  output  3  registered one-hot current owner; 3'b000 = no owner.
REQ-010 busy  output  1  registered; high whenever state != IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, HOLD and OPEN.
REQ-012 In IDLE with req != 0, the block SHALL grant the highest-priority requester, load hold_cnt = HOLD_CYCLES-1 and enter HOLD; grant SHALL appear one cycle after req is sampled.
REQ-013 In IDLE with req == 0, the block SHALL hold grant = 0, all digits = 4'hF and busy = 0.
REQ-014 In HOLD, the owner SHALL keep grant regardless of req, including when the owner deasserts its own req; hold_cnt SHALL decrement by 1 per cycle.
REQ-015 In HOLD with hold_cnt == 0, the block SHALL enter OPEN on the next cycle without changing grant; a HOLD tenure therefore lasts exactly HOLD_CYCLES cycles.
REQ-016 OPEN decision, in this order: a higher-priority req present -> switch to that source, reload hold_cnt, enter HOLD; else owner req still high -> remain OPEN; else any other req -> grant the highest pending, reload, enter HOLD; else -> IDLE with grant = 0.
REQ-017 Every grant change SHALL take effect on the clock edge that ends the deciding cycle; grant SHALL never carry more than one bit set.
REQ-018 Each cycle with an owner, digit_n SHALL be loaded from the owner's live nibble n (one-cycle latency); values 4'hA-4'hF SHALL pass through unmodified.
REQ-019 blink_cnt SHALL count 0..BLINK_HALF-1 and wrap; blink_phase SHALL toggle at each wrap.
REQ-020 On every grant change, including from IDLE, blink_cnt and blink_phase SHALL be cleared to 0, so each new owner starts in the visible half.
REQ-021 When the owner's blink_en = 1 and blink_phase = 1, all five digits SHALL be 4'hF; with blink_en = 0, digits SHALL always be shown.
REQ-022 A change of blink_en mid-tenure SHALL take effect on the next digit update and SHALL NOT reset blink_cnt.
REQ-023 A req arriving in the same cycle that hold_cnt reaches 0 SHALL be arbitrated in the following OPEN cycle.

Reset
REQ-024 While reset = 1 at a rising clk edge, the block SHALL set state = IDLE, grant = 3'b000, busy = 0, digit_0..digit_4 = 4'hF, and hold_cnt = blink_cnt = blink_phase = 0.
REQ-025 Reset SHALL take precedence over every other event, including mid-HOLD or mid-OPEN, and outputs SHALL reflect the reset values one edge after reset is sampled.

Verification (HOLD_CYCLES = 4, BLINK_HALF = 3)
REQ-026 Basic grant: after reset, apply req = 3'b100 with src2_digits = 20'h12345 -> next cycle grant = 3'b100, busy = 1, digit_4..digit_0 = 1,2,3,4,5.
REQ-027 No preemption during HOLD: with src2 owner, assert req[0] one cycle into HOLD -> grant stays 3'b100 for the 4 HOLD cycles, then switches to 3'b001 one cycle after OPEN is entered.
REQ-028 Owner drop: src1 owner deasserts req during HOLD with no other req -> grant = 3'b010 through HOLD, then IDLE, grant = 0, digits = 4'hF, busy = 0.
REQ-029 Simultaneous requests: req = 3'b110 from IDLE -> grant = 3'b010.
REQ-030 Blink: src1 owner with blink_en[1] = 1 and src1_digits = 20'h00042 -> digits 0,0,0,4,2 for 3 cycles, 4'hF for 3 cycles, repeating.
REQ-031 Reset mid-HOLD: assert reset during HOLD -> next cycle grant = 0, busy = 0, all digits = 4'hF; after release with req = 3'b001, a fresh 4-cycle HOLD starts.
